// File: rtl/gmii_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// gmii_tx_arbiter_if
//   Bundles every signal between the two frame sources, the arbiter and the
//   GMII-to-RGMII TX converter.
//   master : frame-source side (drives req/tx_en/tx_data, sees gnt, GMII, status)
//   slave  : arbiter side
//   Signals:
//     req0/req1          source has a frame pending (level)
//     gnt0/gnt1          level grant, at most one high
//     tx_en0/tx_en1      source frame-valid
//     tx_data0/tx_data1  source byte, valid with tx_en
//     gmii_tx_en/data    muxed, registered stream to the converter
//     busy               arbiter not idle
//     err_timeout        one-cycle pulse: grant revoked, source never started
//     err_oversize       one-cycle pulse: frame truncated at maximum length
// ---------------------------------------------------------------------------
interface gmii_tx_arbiter_if;
  logic       req0;
  logic       req1;
  logic       gnt0;
  logic       gnt1;
  logic       tx_en0;
  logic       tx_en1;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic       gmii_tx_en;
  logic [7:0] gmii_tx_data;
  logic       busy;
  logic       err_timeout;
  logic       err_oversize;

  modport master (
    output req0, req1, tx_en0, tx_en1, tx_data0, tx_data1,
    input  gnt0, gnt1, gmii_tx_en, gmii_tx_data, busy, err_timeout, err_oversize
  );

  modport slave (
    input  req0, req1, tx_en0, tx_en1, tx_data0, tx_data1,
    output gnt0, gnt1, gmii_tx_en, gmii_tx_data, busy, err_timeout, err_oversize
  );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// ---------------------------------------------------------------------------
// gmii_tx_arbiter
//   Shares one GMII TX path between two frame sources (0: ARP, 1: UDP).
//   Round-robin grant, one registered cycle of latency on the byte stream,
//   inter-frame gap, start timeout and maximum frame length enforcement.
//   Ports:
//     gmii_tx_clk  125 MHz GMII TX clock, all logic on the rising edge
//     rst          asynchronous active-high reset (release synchronised here)
//     bus          gmii_tx_arbiter_if.slave (sources, GMII output, status)
// ---------------------------------------------------------------------------
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int MAX_LEN       = 1526,
  parameter int START_TIMEOUT = 16,
  parameter int CNT_W         = 11
) (
  input  logic              gmii_tx_clk,
  input  logic              rst,
  gmii_tx_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_DRAIN,
    S_IFG
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IFG_LAST     = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT      = CNT_W'(MAX_LEN);

  // NOTE: reset asserts asynchronously but releases two edges later, so no
  // flop sees reset removal close to a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_i;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_i = rst_sync_q[1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_served_q, last_served_d;  // also selects the granted source
  logic             gmii_tx_en_q, gmii_tx_en_d;
  logic [7:0]       gmii_tx_data_q, gmii_tx_data_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_oversize_q, err_oversize_d;

  logic             fwd;
  logic             tx_en_w;
  logic [7:0]       tx_data_w;
  logic             granted;

  assign tx_en_w   = last_served_q ? bus.tx_en1   : bus.tx_en0;
  assign tx_data_w = last_served_q ? bus.tx_data1 : bus.tx_data0;

  always_ff @(posedge gmii_tx_clk or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      last_served_q  <= 1'b1;   // source 0 wins the first tie
      gmii_tx_en_q   <= 1'b0;
      gmii_tx_data_q <= 8'h00;
      err_timeout_q  <= 1'b0;
      err_oversize_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_served_q  <= last_served_d;
      gmii_tx_en_q   <= gmii_tx_en_d;
      gmii_tx_data_q <= gmii_tx_data_d;
      err_timeout_q  <= err_timeout_d;
      err_oversize_q <= err_oversize_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_served_d  = last_served_q;
    fwd            = 1'b0;
    err_timeout_d  = 1'b0;
    err_oversize_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Contested: the source not served last; otherwise the lone requester.
          last_served_d = (bus.req0 && bus.req1) ? ~last_served_q : bus.req1;
          cnt_d         = '0;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: begin
        if (tx_en_w) begin
          fwd     = 1'b1;       // first byte already counts towards the length
          cnt_d   = CNT_ONE;
          state_d = S_SEND;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_IFG;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SEND: begin
        if (!tx_en_w) begin
          cnt_d   = '0;
          state_d = S_IFG;
        end else if (cnt_q < MAX_CNT) begin
          fwd   = 1'b1;
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          err_oversize_d = 1'b1;
          state_d        = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!tx_en_w) begin
          cnt_d   = '0;
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    gmii_tx_en_d   = fwd;
    gmii_tx_data_d = fwd ? tx_data_w : 8'h00;
  end

  // Grant is decoded from the state register so it drops on the same edge
  // the FSM leaves GRANT/SEND/DRAIN, and immediately on reset.
  assign granted          = (state_q == S_GRANT) || (state_q == S_SEND) || (state_q == S_DRAIN);
  assign bus.gnt0         = granted && !last_served_q;
  assign bus.gnt1         = granted &&  last_served_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.gmii_tx_en   = gmii_tx_en_q;
  assign bus.gmii_tx_data = gmii_tx_data_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.err_oversize = err_oversize_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gmii_tx_arbiter
//   Directed scenarios plus randomised frame pairs for gmii_tx_arbiter.
//   Sources are modelled as independent drivers fed from job queues; a
//   monitor reassembles frames from the GMII side and records event times;
//   the expected frame order, lengths, bytes and error pulses come from a
//   simple arbitration model of the frame-level rules.
// ---------------------------------------------------------------------------
module tb_gmii_tx_arbiter;

  localparam int IFG_CYCLES    = 12;
  localparam int MAX_LEN       = 1526;
  localparam int START_TIMEOUT = 16;

  typedef struct {
    int len;
    int seed;
    int stride;
    bit no_start;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  gmii_tx_arbiter_if bus ();

  gmii_tx_arbiter #(
    .IFG_CYCLES   (IFG_CYCLES),
    .MAX_LEN      (MAX_LEN),
    .START_TIMEOUT(START_TIMEOUT),
    .CNT_W        (11)
  ) dut (
    .gmii_tx_clk(clk),
    .rst        (rst),
    .bus        (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ sources
  bit noise_en [2];

  for (genvar s = 0; s < 2; s++) begin : g_drv
    job_t       jobq[$];
    logic       req_l;
    logic       en_l;
    logic [7:0] data_l;
    bit         active;
    wire        gnt_l = (s == 0) ? bus.gnt0 : bus.gnt1;

    initial begin
      job_t j;
      bit   got;
      req_l = 1'b0; en_l = 1'b0; data_l = 8'h00; active = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          req_l = 1'b0; en_l = 1'b0; data_l = 8'h00;
        end else if (jobq.size() != 0) begin
          j = jobq.pop_front();
          active = 1'b1;
          en_l = 1'b0; data_l = 8'h00;
          req_l = 1'b1;
          got = 1'b0;
          for (int i = 0; i < 4000 && !got && !rst; i++) begin
            @(negedge clk);
            got = gnt_l;
          end
          req_l = 1'b0;
          if (got && !j.no_start) begin
            for (int i = 0; i < j.len && !rst; i++) begin
              en_l = 1'b1;
              data_l = 8'(j.seed + i * j.stride);
              @(negedge clk);
            end
          end
          en_l = 1'b0; data_l = 8'h00;
          for (int i = 0; i < 100 && gnt_l && !rst; i++) @(negedge clk);
          active = 1'b0;
        end else begin
          en_l   = noise_en[s] ? 1'($urandom) : 1'b0;
          data_l = en_l ? 8'($urandom) : 8'h00;
        end
      end
    end
  end

  assign bus.req0     = g_drv[0].req_l;
  assign bus.tx_en0   = g_drv[0].en_l;
  assign bus.tx_data0 = g_drv[0].data_l;
  assign bus.req1     = g_drv[1].req_l;
  assign bus.tx_en1   = g_drv[1].en_l;
  assign bus.tx_data1 = g_drv[1].data_l;

  // ------------------------------------------------------------ monitor
  int         cyc = 0;
  int         t_req_rise[2], t_gnt_rise[2], t_gnt_fall[2];
  int         t_en_rise, t_en_fall, t_busy_fall, t_err_t, t_err_o;
  int         n_err_t = 0, n_err_o = 0;
  int         cur_len = 0, cur_src = 0;
  bit         have_prev = 1'b0;
  logic [1:0] prev_req = '0, prev_gnt = '0;
  logic       prev_en = 1'b0, prev_busy = 1'b0, prev_t = 1'b0, prev_o = 1'b0;
  logic [7:0] cur_q[$];
  int         got_src[$], got_len[$];
  logic [7:0] got_bytes[$];

  always @(posedge clk) begin
    logic [1:0] rq, gn;
    #1;
    cyc++;
    rq = {bus.req1, bus.req0};
    gn = {bus.gnt1, bus.gnt0};
    if (rst) begin
      cur_q.delete(); cur_len = 0; have_prev = 1'b0;
      prev_req = '0; prev_gnt = '0; prev_en = 1'b0;
      prev_busy = 1'b0; prev_t = 1'b0; prev_o = 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (rq[s] && !prev_req[s]) t_req_rise[s] = cyc;
        if (gn[s] && !prev_gnt[s]) t_gnt_rise[s] = cyc;
        if (!gn[s] && prev_gnt[s]) t_gnt_fall[s] = cyc;
      end
      if (!bus.busy && prev_busy) t_busy_fall = cyc;
      check("gnt_exclusive", 32'(gn[0] & gn[1]), 32'(0));
      check("data_zero_when_idle", 32'(!bus.gmii_tx_en && (bus.gmii_tx_data != 8'h00)), 32'(0));
      check("err_exclusive", 32'(bus.err_timeout & bus.err_oversize), 32'(0));
      check("err_timeout_one_cycle", 32'(bus.err_timeout & prev_t), 32'(0));
      check("err_oversize_one_cycle", 32'(bus.err_oversize & prev_o), 32'(0));
      if (bus.err_timeout && !prev_t) begin n_err_t++; t_err_t = cyc; end
      if (bus.err_oversize && !prev_o) begin n_err_o++; t_err_o = cyc; end
      if (bus.gmii_tx_en) begin
        if (!prev_en) begin
          t_en_rise = cyc;
          if (have_prev) check("ifg_gap_min", 32'(cyc - t_en_fall >= IFG_CYCLES + 2), 32'(1));
          cur_src = gn[1] ? 1 : 0;
          cur_len = 0;
        end
        cur_q.push_back(bus.gmii_tx_data);
        cur_len++;
      end else if (prev_en) begin
        t_en_fall = cyc;
        have_prev = 1'b1;
        got_src.push_back(cur_src);
        got_len.push_back(cur_len);
        foreach (cur_q[i]) got_bytes.push_back(cur_q[i]);
        cur_q.delete();
        cur_len = 0;
      end
      prev_req = rq; prev_gnt = gn; prev_en = bus.gmii_tx_en;
      prev_busy = bus.busy; prev_t = bus.err_timeout; prev_o = bus.err_oversize;
    end
  end

  // ------------------------------------------------------------ reference model
  int   m_last = 1;
  job_t exp_job[$];
  int   exp_src[$];
  int   exp_err_t = 0, exp_err_o = 0;

  task automatic model_serve(input int s, input job_t j);
    m_last = s;
    if (j.no_start) exp_err_t++;
    else begin
      exp_src.push_back(s);
      exp_job.push_back(j);
      if (j.len > MAX_LEN) exp_err_o++;
    end
  endtask

  task automatic push_job(input int s, input job_t j);
    if (s == 0) g_drv[0].jobq.push_back(j);
    else        g_drv[1].jobq.push_back(j);
  endtask

  // Requests raised together: the source not served last goes first.
  task automatic issue(input bit h0, input job_t j0, input bit h1, input job_t j1);
    if (h0 && h1) begin
      if (m_last == 0) begin model_serve(1, j1); model_serve(0, j0); end
      else             begin model_serve(0, j0); model_serve(1, j1); end
    end else if (h0) model_serve(0, j0);
    else if (h1)     model_serve(1, j1);
    if (h0) push_job(0, j0);
    if (h1) push_job(1, j1);
  endtask

  function automatic job_t mk_job(input int len, input int seed, input int stride, input bit ns);
    job_t j;
    j.len = len; j.seed = seed; j.stride = stride; j.no_start = ns;
    return j;
  endfunction

  function automatic job_t rand_job();
    return mk_job(($urandom_range(0, 7) == 0) ? 1 : $urandom_range(1, 120),
                  $urandom_range(0, 255), $urandom_range(0, 127) * 2 + 1,
                  $urandom_range(0, 5) == 0);
  endfunction

  task automatic wait_idle();
    bit expired = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (g_drv[0].jobq.size() == 0 && g_drv[1].jobq.size() == 0 &&
          !g_drv[0].active && !g_drv[1].active && !bus.busy) begin
        expired = 1'b0;
        break;
      end
    end
    check("wait_idle_expired", 32'(expired), 32'(0));
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_frame_count"}, 32'(got_len.size()), 32'(exp_job.size()));
    while (exp_job.size() > 0 && got_len.size() > 0) begin
      job_t j  = exp_job.pop_front();
      int   s  = exp_src.pop_front();
      int   gl = got_len.pop_front();
      int   gs = got_src.pop_front();
      int   el = (j.len > MAX_LEN) ? MAX_LEN : j.len;
      int   bad = gl;
      for (int i = 0; i < gl; i++) begin
        logic [7:0] b = got_bytes.pop_front();
        if (bad == gl && b !== 8'(j.seed + i * j.stride)) bad = i;
      end
      check({tag, "_frame_src"}, 32'(gs), 32'(s));
      check({tag, "_frame_len"}, 32'(gl), 32'(el));
      check({tag, "_frame_first_bad_byte"}, 32'(bad), 32'(gl));
    end
    exp_job.delete(); exp_src.delete();
    got_len.delete(); got_src.delete(); got_bytes.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, 32'({bus.gnt0, bus.gnt1, bus.gmii_tx_en, bus.gmii_tx_data,
                    bus.busy, bus.err_timeout, bus.err_oversize}), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset_async_outputs");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    m_last = 1;
  endtask

  // ------------------------------------------------------------ directed + random
  initial begin
    job_t j0, j1, jx;
    noise_en[0] = 1'b0;
    noise_en[1] = 1'b0;
    jx = mk_job(1, 0, 1, 1'b0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs_zero("idle_after_release");

    // 1: single 64-byte frame 0x00..0x3F from source 0
    issue(1'b1, mk_job(64, 0, 1, 1'b0), 1'b0, jx);
    wait_idle();
    compare_frames("t1");
    check("t1_gnt_latency", 32'(t_gnt_rise[0] - t_req_rise[0]), 32'(0));
    check("t1_first_byte_latency", 32'(t_en_rise - t_gnt_rise[0]), 32'(1));
    check("t1_en_high_cycles", 32'(t_en_fall - t_en_rise), 32'(64));
    check("t1_gnt_drop_at_end", 32'(t_gnt_fall[0] - t_en_fall), 32'(0));
    check("t1_busy_tail", 32'(t_busy_fall - t_en_fall), 32'(IFG_CYCLES));

    // 2: two simultaneous pairs after reset, 60 bytes each
    do_reset();
    for (int p = 0; p < 2; p++) begin
      j0 = mk_job(60, $urandom_range(0, 255), 1, 1'b0);
      j1 = mk_job(60, $urandom_range(0, 255), 3, 1'b0);
      issue(1'b1, j0, 1'b1, j1);
      wait_idle();
    end
    compare_frames("t2");

    // 3: source 1 never starts, source 0 waits behind it
    issue(1'b0, jx, 1'b1, mk_job(10, 0, 1, 1'b1));
    repeat (3) @(negedge clk);
    issue(1'b1, mk_job(40, $urandom_range(0, 255), 5, 1'b0), 1'b0, jx);
    wait_idle();
    compare_frames("t3");
    check("t3_gnt1_hold", 32'(t_gnt_fall[1] - t_gnt_rise[1]), 32'(START_TIMEOUT));
    check("t3_err_timeout_time", 32'(t_err_t), 32'(t_gnt_fall[1]));
    check("t3_next_grant_delay", 32'(t_gnt_rise[0] - t_gnt_fall[1]), 32'(IFG_CYCLES + 1));
    check("t3_err_timeout_count", 32'(n_err_t), 32'(exp_err_t));

    // 4: oversize frame is truncated, grant held until the source stops
    issue(1'b1, mk_job(1600, $urandom_range(0, 255), 7, 1'b0), 1'b0, jx);
    wait_idle();
    compare_frames("t4");
    check("t4_forwarded_cycles", 32'(t_en_fall - t_en_rise), 32'(MAX_LEN));
    check("t4_err_oversize_time", 32'(t_err_o), 32'(t_en_fall));
    check("t4_gnt_hold", 32'(t_gnt_fall[0] - t_en_rise), 32'(1600));
    check("t4_err_oversize_count", 32'(n_err_o), 32'(exp_err_o));

    // 5: ungranted source toggles tx_en during a frame
    noise_en[1] = 1'b1;
    issue(1'b1, mk_job(80, $urandom_range(0, 255), 9, 1'b0), 1'b0, jx);
    wait_idle();
    noise_en[1] = 1'b0;
    compare_frames("t5");

    // 6: reset mid-frame, then a clean frame
    push_job(0, mk_job(100, 0, 1, 1'b0));
    for (int i = 0; i < 500 && cur_len < 30; i++) @(negedge clk);
    check("t6_reached_byte_30", 32'(cur_len >= 30), 32'(1));
    #2 rst = 1'b1;
    #1 check("t6_reset_midframe", 32'({bus.gmii_tx_en, bus.gnt0, bus.busy}), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    m_last = 1;
    issue(1'b1, mk_job(64, $urandom_range(0, 255), 1, 1'b0), 1'b0, jx);
    wait_idle();
    compare_frames("t6");

    // random pairs
    for (int r = 0; r < 20; r++) begin
      int sel = $urandom_range(0, 2);
      issue(sel != 1, rand_job(), sel != 0, rand_job());
      wait_idle();
      compare_frames("rand");
    end
    check("final_err_timeout_count", 32'(n_err_t), 32'(exp_err_t));
    check("final_err_oversize_count", 32'(n_err_o), 32'(exp_err_o));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
